// File: rtl/meas_capture_sequencer.sv
// ADC->RAM capture run sequencer with RAM readout pointer for the VNA DSP core.
// Optional capture watchdog enabled by defining MEAS_SEQ_TIMEOUT_EN.
module meas_capture_sequencer #(
    parameter int ADC_WIDTH   = 12,
    parameter int MAX_POINTS  = 4096,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(MAX_POINTS):0]  cfg_points,
    input  logic [15:0]                  cfg_settle,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         conv_strobe,
    input  logic [2*ADC_WIDTH-1:0]       adc_data,
    output logic                         ram_wr_en,
    output logic [$clog2(MAX_POINTS)-1:0] ram_wr_addr,
    output logic [2*ADC_WIDTH-1:0]       ram_wr_data,
    input  logic                         rd_req,
    input  logic                         rd_rewind,
    output logic                         ram_rd_en,
    output logic [$clog2(MAX_POINTS)-1:0] ram_rd_addr,
    input  logic [2*ADC_WIDTH-1:0]       rd_data,
    output logic                         rd_valid,
    output logic [2*ADC_WIDTH-1:0]       rd_sample,
    output logic                         rd_empty,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(MAX_POINTS):0]  sample_cnt,
    output logic                         err_timeout
);

    localparam int AW = $clog2(MAX_POINTS);
    localparam logic [AW:0] NMAX = (AW+1)'(MAX_POINTS);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_CAPTURE, S_DONE, S_ERROR
    } state_t;

    state_t      state, state_nx;
    logic [15:0] settle_cnt;
    logic [AW:0] n_lat;
    logic [AW:0] rd_ptr;
    logic [AW:0] pts_clamped;
    logic [RD_LAT-1:0] rd_pipe;
    logic        start_ok, last_wr, strobe_ok, rd_ok, rd_busy, tmo_hit;

    assign pts_clamped = (cfg_points == '0 || cfg_points > NMAX) ? NMAX : cfg_points;
    assign start_ok = start && !abort &&
                      (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign last_wr  = ram_wr_en && ((sample_cnt + 1'b1) == n_lat);
    // A strobe landing on the final write cycle would write outside CAPTURE
    assign strobe_ok = conv_strobe && state == S_CAPTURE && !abort &&
                       !last_wr && !tmo_hit;

`ifdef MEAS_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = state == S_CAPTURE && !conv_strobe &&
                     tmo_cnt == TW'(TIMEOUT_CYC - 1);
    assign err_timeout = (state == S_ERROR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state != S_CAPTURE || conv_strobe)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    // Watchdog absent: constant-false, ERROR never entered
    assign tmo_hit     = (TIMEOUT_CYC < 0);
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR:
                if (start_ok)
                    state_nx = (cfg_settle != '0) ? S_SETTLE : S_CAPTURE;
            S_SETTLE:
                if (settle_cnt == 16'd1) state_nx = S_CAPTURE;
            S_CAPTURE:
                if (last_wr)      state_nx = S_DONE;
                else if (tmo_hit) state_nx = S_ERROR;
            default: state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    assign busy        = (state == S_SETTLE || state == S_CAPTURE);
    assign done        = (state == S_DONE);
    assign ram_wr_addr = sample_cnt[AW-1:0];
    assign rd_empty    = (rd_ptr >= sample_cnt);
    assign rd_busy     = ram_rd_en || (|rd_pipe);
    assign rd_ok       = rd_req && !rd_rewind && !start_ok && !busy &&
                         (rd_ptr < sample_cnt) && !rd_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            settle_cnt  <= '0;
            n_lat       <= NMAX;
            sample_cnt  <= '0;
            ram_wr_en   <= 1'b0;
            ram_wr_data <= '0;
            rd_ptr      <= '0;
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
            rd_pipe     <= '0;
            rd_valid    <= 1'b0;
            rd_sample   <= '0;
        end else begin
            state <= state_nx;

            if (start_ok) begin
                n_lat      <= pts_clamped;
                settle_cnt <= cfg_settle;
            end else if (state == S_SETTLE) begin
                settle_cnt <= settle_cnt - 1'b1;
            end

            ram_wr_en <= strobe_ok;
            if (strobe_ok) ram_wr_data <= adc_data;

            if (start_ok)       sample_cnt <= '0;
            else if (ram_wr_en) sample_cnt <= sample_cnt + 1'b1;

            if (start_ok || rd_rewind) rd_ptr <= '0;
            else if (rd_ok)            rd_ptr <= rd_ptr + 1'b1;

            ram_rd_en <= rd_ok;
            if (rd_ok) ram_rd_addr <= rd_ptr[AW-1:0];

            rd_pipe  <= (rd_pipe << 1) | RD_LAT'(ram_rd_en);
            rd_valid <= rd_pipe[RD_LAT-1];
            if (rd_pipe[RD_LAT-1]) rd_sample <= rd_data;
        end
    end

endmodule

// File: tb/tb_meas_capture_sequencer.sv
// Self-checking bench for meas_capture_sequencer (default build, watchdog off).
// Capture runs are checked against an offset-based model of accepted strobes.
module tb_meas_capture_sequencer;

    localparam int AW   = 12;
    localparam int DW   = 24;
    localparam int MAXP = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW:0]   cfg_points = '0;
    logic [15:0]   cfg_settle = '0;
    logic          start = 1'b0, abort = 1'b0, conv_strobe = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          rd_req = 1'b0, rd_rewind = 1'b0;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_sample;
    logic          rd_empty, busy, done, err_timeout;
    logic [AW:0]   sample_cnt;

    meas_capture_sequencer dut (
        .clk(clk), .rst(rst),
        .cfg_points(cfg_points), .cfg_settle(cfg_settle),
        .start(start), .abort(abort),
        .conv_strobe(conv_strobe), .adc_data(adc_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data),
        .rd_req(rd_req), .rd_rewind(rd_rewind),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_sample(rd_sample),
        .rd_empty(rd_empty), .busy(busy), .done(done),
        .sample_cnt(sample_cnt), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // RAM with one cycle read latency
    logic [DW-1:0] mem [MAXP];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) rd_data <= mem[ram_rd_addr];
    end

    logic [AW+DW-1:0] wq [$];
    logic [AW-1:0]    rq [$];
    logic [DW-1:0]    vq [$];
    logic [DW-1:0]    expd [$];
    int               soffs [$];
    int               bad_wr = 0;
    int               checks = 0;
    int               errors = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_wr_en) begin
                wq.push_back({ram_wr_addr, ram_wr_data});
                if (!busy) bad_wr++;
            end
            if (ram_rd_en) rq.push_back(ram_rd_addr);
            if (rd_valid)  vq.push_back(rd_sample);
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drives start at offset 0 and strobes at soffs; the model accepts a
    // strobe if it falls after the settle window and before n_lat is reached.
    task automatic run_capture(input int pts, input int settle);
        int nlat, last, k;
        wq.delete();
        expd.delete();
        nlat = (pts == 0 || pts > MAXP) ? MAXP : pts;
        last = (soffs.size() > 0) ? soffs[soffs.size()-1] : 0;
        cfg_points = (AW+1)'(pts);
        cfg_settle = 16'(settle);
        start = 1'b1;
        k = 0;
        for (int d = 0; d <= last + 3; d++) begin
            if (d == 1) chk("busy_after_start", busy, 1);
            conv_strobe = 1'b0;
            if (k < soffs.size() && soffs[k] == d) begin
                conv_strobe = 1'b1;
                adc_data = DW'($urandom);
                if (d >= settle + 1 && expd.size() < nlat)
                    expd.push_back(adc_data);
                k++;
            end
            @(negedge clk);
            start = 1'b0;
            conv_strobe = 1'b0;
        end
        chk("wr_count", wq.size(), expd.size());
        for (int i = 0; i < wq.size() && i < expd.size(); i++) begin
            chk("wr_addr", wq[i][AW+DW-1:DW], i);
            chk("wr_data", wq[i][DW-1:0], expd[i]);
        end
        chk("sample_cnt", sample_cnt, expd.size());
        chk("done", done, expd.size() == nlat);
        chk("busy", busy, expd.size() != nlat);
    endtask

    task automatic do_abort();
        int cnt;
        cnt = expd.size();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_cnt", sample_cnt, cnt);
    endtask

    task automatic read_n(input int m, input int cnt);
        int nv;
        rq.delete();
        vq.delete();
        for (int i = 0; i < m; i++) begin
            rd_req = 1'b1;
            @(negedge clk);
            rd_req = 1'b0;
            repeat (4) @(negedge clk);
        end
        nv = (m < cnt) ? m : cnt;
        chk("rd_count", vq.size(), nv);
        chk("rd_en_count", rq.size(), nv);
        for (int i = 0; i < vq.size() && i < nv; i++) begin
            chk("rd_data", vq[i], expd[i]);
            if (i < rq.size()) chk("rd_addr", rq[i], i);
        end
        if (m >= cnt) chk("rd_empty", rd_empty, 1);
    endtask

    typedef struct {
        int pts;
        int settle;
        int spacing;
        int nstb;
        int exp_cnt;
        bit exp_done;
    } vec_t;

    vec_t tab [6];

    initial begin
        tab[0] = '{8,    5, 4, 10,   8,    1'b1};
        tab[1] = '{0,    0, 2, 4100, 4096, 1'b1};
        tab[2] = '{5000, 0, 2, 4100, 4096, 1'b1};
        tab[3] = '{3,    0, 1, 5,    3,    1'b1};
        tab[4] = '{4,    2, 1, 6,    4,    1'b1};
        tab[5] = '{10,   1, 3, 5,    4,    1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_en", ram_wr_en, 0);
        chk("rst_rd_en", ram_rd_en, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", sample_cnt, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_empty", rd_empty, 1);
        chk("rst_sample", rd_sample, 0);

        foreach (tab[t]) begin
            soffs.delete();
            for (int j = 0; j < tab[t].nstb; j++)
                soffs.push_back(1 + j * tab[t].spacing);
            run_capture(tab[t].pts, tab[t].settle);
            chk("tab_cnt", sample_cnt, tab[t].exp_cnt);
            chk("tab_done", done, tab[t].exp_done);
            if (busy) do_abort();
        end

        // abort + start + strobe together mid-capture at sample 3
        soffs = '{1, 3, 5};
        run_capture(10, 0);
        abort = 1'b1;
        start = 1'b1;
        conv_strobe = 1'b1;
        adc_data = DW'($urandom);
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        conv_strobe = 1'b0;
        @(negedge clk);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_cnt", sample_cnt, 3);
        chk("ab_no_write", wq.size(), 3);

        // readout of a 4-sample run, rewind beats rd_req
        soffs = '{1, 2, 3, 4};
        run_capture(4, 0);
        read_n(5, 4);
        rq.delete();
        rd_rewind = 1'b1;
        rd_req = 1'b1;
        @(negedge clk);
        rd_rewind = 1'b0;
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rewind_no_read", rq.size(), 0);
        chk("rewind_empty", rd_empty, 0);
        read_n(1, 4);

        for (int it = 0; it < 20; it++) begin
            int pts, st;
            pts = $urandom_range(1, 12);
            st  = $urandom_range(0, 6);
            soffs.delete();
            for (int d = 1; d <= 40; d++)
                if ($urandom_range(0, 2) == 0) soffs.push_back(d);
            run_capture(pts, st);
            if (busy) do_abort();
            read_n($urandom_range(0, 14), expd.size());
        end

        chk("no_wr_outside_capture", bad_wr, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
